// File: rtl/rs232_packet_rx.sv
// Receives SYNC/LEN/payload/CHK frames from a byte UART, verifies the 8-bit additive checksum
// and delivers the buffered payload over a valid/ready stream.
module rs232_packet_rx #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic       iCLK_50,
  input  logic       iRST_N,
  input  logic       iRX_TICK,
  input  logic [7:0] iRX_DATA,
  input  logic       iREADY,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oLAST,
  output logic       oPKT_OK,
  output logic       oERR,
  output logic [1:0] oERR_CODE,
  output logic       oOVERRUN,
  output logic       oBUSY
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned LenW = $clog2(MAX_LEN + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StChk, StDeliver, StError} state_e;

  state_e          r_state, w_state_d;
  logic [LenW-1:0] r_len;
  logic [7:0]      r_sum;
  logic [IdxW-1:0] r_wr_idx, r_rd_idx;
  logic [TmoW-1:0] r_tmo;
  logic            r_pkt_ok, r_err, r_overrun;
  logic [1:0]      r_err_code;
  logic [7:0]      r_buf [MAX_LEN];

  logic       w_ok_d, w_err_d, w_ovr_d, w_len_bad, w_tmo_hit, w_timed, w_wr_last, w_xfer;
  logic [1:0] w_code_d;

  assign w_len_bad = (iRX_DATA == 8'd0) || (iRX_DATA > 8'(MAX_LEN));
  assign w_timed   = (r_state == StLen) || (r_state == StPayload) || (r_state == StChk);
  // Counter reads k-1 in the k-th cycle after the last tick, so this is the cycle it reaches TIMEOUT-1.
  assign w_tmo_hit = (r_tmo == TmoW'(TIMEOUT - 2));
  assign w_wr_last = (LenW'(r_wr_idx) == r_len - LenW'(1));
  assign w_xfer    = oVALID && iREADY;

  assign oVALID    = (r_state == StDeliver);
  assign oDATA     = oVALID ? r_buf[r_rd_idx] : 8'h00;
  assign oLAST     = oVALID && (LenW'(r_rd_idx) == r_len - LenW'(1));
  assign oBUSY     = (r_state != StIdle);
  assign oPKT_OK   = r_pkt_ok;
  assign oERR      = r_err;
  assign oERR_CODE = r_err_code;
  assign oOVERRUN  = r_overrun;

  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_err_code;
    w_ok_d    = 1'b0;
    w_ovr_d   = 1'b0;
    case (r_state)
      StIdle: if (iRX_TICK && iRX_DATA == 8'hAA) w_state_d = StLen;
      StLen: begin
        if (iRX_TICK) begin
          if (w_len_bad) begin
            w_state_d = StError;
            w_code_d  = 2'b01;
          end else begin
            w_state_d = StPayload;
          end
        end else if (w_tmo_hit) begin
          w_state_d = StError;
          w_code_d  = 2'b11;
        end
      end
      StPayload: begin
        if (iRX_TICK) begin
          if (w_wr_last) w_state_d = StChk;
        end else if (w_tmo_hit) begin
          w_state_d = StError;
          w_code_d  = 2'b11;
        end
      end
      StChk: begin
        if (iRX_TICK) begin
          if (iRX_DATA == r_sum) begin
            w_state_d = StDeliver;
            w_ok_d    = 1'b1;
          end else begin
            w_state_d = StError;
            w_code_d  = 2'b10;
          end
        end else if (w_tmo_hit) begin
          w_state_d = StError;
          w_code_d  = 2'b11;
        end
      end
      StDeliver: begin
        w_ovr_d = iRX_TICK;
        if (w_xfer && oLAST) w_state_d = StIdle;
      end
      StError: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    w_err_d = (w_state_d == StError);
  end

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_sum      <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_tmo      <= '0;
      r_pkt_ok   <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pkt_ok   <= w_ok_d;
      r_err      <= w_err_d;
      r_err_code <= w_code_d;
      r_overrun  <= w_ovr_d;
      if (iRX_TICK || !w_timed) r_tmo <= '0;
      else                      r_tmo <= r_tmo + TmoW'(1);
      if (r_state == StLen && iRX_TICK && !w_len_bad) begin
        r_len    <= iRX_DATA[LenW-1:0];
        r_sum    <= iRX_DATA;
        r_wr_idx <= '0;
      end
      if (r_state == StPayload && iRX_TICK) begin
        r_sum    <= r_sum + iRX_DATA;
        r_wr_idx <= r_wr_idx + IdxW'(1);
      end
      if (r_state == StChk) r_rd_idx <= '0;
      else if (w_xfer)      r_rd_idx <= r_rd_idx + IdxW'(1);
    end
  end

  always_ff @(posedge iCLK_50) begin
    if (r_state == StPayload && iRX_TICK) r_buf[r_wr_idx] <= iRX_DATA;
  end

endmodule

// File: doc/rs232_packet_rx.md
RS232_PACKET_RX -- requirements
Module: rs232_packet_rx

Interface
REQ-001 Parameter MAX_LEN, 16, maximum payload length in bytes (1..16).
REQ-002 Parameter TIMEOUT, 200000, inter-byte timeout in iCLK_50 cycles (4 ms).
REQ-003 iCLK_50  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 iRST_N  input  1  reset, asynchronous, active-low.
REQ-005 iRX_TICK  input  1  one-cycle pulse: the upstream UART receiver has completed a byte.
REQ-006 iRX_DATA  input  8  received byte; valid in the iRX_TICK cycle.
REQ-007 iREADY  input  1  downstream sink accepts oDATA this cycle.
REQ-008 oDATA  output  8  payload byte being delivered.
REQ-009 oVALID  output  1  oDATA is valid.
REQ-010 oLAST  output  1  oDATA is the final payload byte of the packet.
REQ-011 oPKT_OK  output  1  one-cycle pulse: the packet passed the checksum.
REQ-012 oERR  output  1  one-cycle pulse: the packet was discarded.
REQ-013 oERR_CODE  output  2  error cause, valid with oERR: 01 bad length, 10 checksum, 11 timeout.
REQ-014 oOVERRUN  output  1  one-cycle pulse: a byte arrived during DELIVER and was dropped.
REQ-015 oBUSY  output  1  high in every state except IDLE.

Function
REQ-016 The frame format SHALL be: SYNC 0xAA, LEN, LEN payload bytes, CHK.
REQ-017 The FSM SHALL have exactly six states: IDLE, LEN, PAYLOAD, CHK, DELIVER, and a one-cycle ERROR state.
REQ-018 IDLE: on iRX_TICK with iRX_DATA==0xAA, go to LEN; all other bytes are ignored silently.
REQ-019 LEN: on iRX_TICK, if the byte is 0 or greater than MAX_LEN, go to ERROR with code 01.
REQ-020 LEN: on iRX_TICK with a valid byte, latch it as the length, seed the sum with it, clear the write index, and go to PAYLOAD.
REQ-021 PAYLOAD: on each iRX_TICK, store the byte at buffer[wr_idx], add it to the sum, and increment wr_idx.
REQ-022 PAYLOAD: when the stored byte is byte number LEN, go to CHK.
REQ-023 CHK: on iRX_TICK, if the byte equals sum[7:0], pulse oPKT_OK and go to DELIVER.
REQ-024 CHK: on iRX_TICK, if the byte does not equal sum[7:0], go to ERROR with code 10.
REQ-025 The sum SHALL be 8-bit, modulo 256, and wrap without a carry flag.
REQ-026 oPKT_OK and oERR SHALL be registered and asserted on the cycle after the deciding iRX_TICK.
REQ-027 Timeout counter: cleared on every iRX_TICK and on entry to LEN; increments each cycle in LEN, PAYLOAD and CHK.
REQ-028 When the timeout counter reaches TIMEOUT-1, go to ERROR with code 11.
REQ-029 If iRX_TICK and timeout coincide, the tick SHALL win and no timeout SHALL occur.
REQ-030 ERROR: pulse oERR for one cycle with oERR_CODE held, then go to IDLE.
REQ-031 ERROR: an iRX_TICK arriving in the ERROR cycle SHALL be ignored.
REQ-032 DELIVER: present buffer[rd_idx] starting at rd_idx=0; oVALID is high from the first DELIVER cycle.
REQ-033 A transfer SHALL occur when oVALID and iREADY are both high.
REQ-034 oDATA, oVALID and oLAST SHALL stay stable until a transfer occurs.
REQ-035 oLAST SHALL be high only when rd_idx==LEN-1.
REQ-036 After the transfer with oLAST high, oVALID SHALL drop the next cycle and the FSM SHALL return to IDLE.
REQ-037 Each iRX_TICK during DELIVER SHALL pulse oOVERRUN on the next cycle; the byte is dropped, and a 0xAA is not treated as SYNC.
REQ-038 oERR_CODE SHALL hold its last value between errors.

Reset
REQ-039 When iRST_N is low, the FSM SHALL go to IDLE and the sum, indices, length and timeout counter SHALL clear.
REQ-040 When iRST_N is low, oVALID, oLAST, oPKT_OK, oERR, oOVERRUN and oBUSY SHALL be 0, oDATA 0x00, and oERR_CODE 00.
REQ-041 Buffer contents SHALL need no reset.
REQ-042 Reset mid-packet or mid-DELIVER SHALL abandon the packet with no oERR pulse.
REQ-043 After reset release, the block SHALL wait for a new SYNC byte.

Verification
REQ-044 Good packet: bytes AA 03 11 22 33 69 with iREADY=1 -> oPKT_OK pulse, then 11, 22, 33 delivered on consecutive cycles, oLAST on 33, oBUSY low afterwards.
REQ-045 Checksum error: AA 02 10 20 00 -> oERR with code 10, no oVALID; a following AA 01 05 06 -> oPKT_OK and 05 delivered with oLAST.
REQ-046 Bad length: AA 00 and AA 11 (MAX_LEN=16) -> oERR with code 01 after the length byte each time; the block returns to IDLE.
REQ-047 Timeout: AA 04 01 then silence -> oERR with code 11 exactly TIMEOUT cycles after the 01 tick; a tick landing on cycle TIMEOUT-1 produces no timeout.
REQ-048 Backpressure and overrun: good 2-byte packet with iREADY held low for 10 cycles -> oDATA/oVALID stable; an injected iRX_TICK gives one oOVERRUN pulse; delivery completes after iREADY rises.
REQ-049 Reset mid-PAYLOAD: iRST_N low after AA 03 01 -> all outputs 0, no oERR; the next good frame decodes correctly.
